cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the ALU reservation station and the load/store buffer.
- Each producer writes results into its own small result queue.
- Each cycle the arbiter grants one non-empty queue round-robin and broadcasts that entry on a registered CDB.
- Consumers (RoB, RS, LSB) then see exactly one writeback per cycle; a RoB mispredict flushes all pending results.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_result_queue.sv | 82 ++++++++
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared widths and encodings for the common data bus arbiter.
//   ADDR_WIDTH : pc width
//   RoB_WIDTH  : reorder-buffer tag width
//   VAL_WIDTH  : result value width
//   NON_DEP    : tag value consumers use to mean "no pending producer"
//   SRC_RS / SRC_LSB : CDB_src encodings
package cdb_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int RoB_WIDTH  = 8;
    localparam int VAL_WIDTH  = 32;

    localparam logic [RoB_WIDTH-1:0] NON_DEP = '1;

    localparam logic SRC_RS  = 1'b0;
    localparam logic SRC_LSB = 1'b1;

endpackage

// File: rtl/cdb_result_queue.sv
// cdb_result_queue
//   Small circular FIFO holding results from one producer until the CDB
//   arbiter grants it.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : global enable; push/pop only take effect when high
//   flush_i      : empties the queue (wins over en_i, push_i, pop_i)
//   push_i/data_i: enqueue at tail (dropped when full)
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : entry at head
//   count_o      : occupancy, 0..Q_DEPTH
module cdb_result_queue #(
    parameter int Q_WIDTH = 2,
    parameter int DATA_W  = 72
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [Q_WIDTH:0]  count_o
);

    localparam int Q_DEPTH = 1 << Q_WIDTH;

    logic [DATA_W-1:0]  mem_q [Q_DEPTH];
    logic [Q_WIDTH-1:0] head_q, head_d;
    logic [Q_WIDTH-1:0] tail_q, tail_d;
    logic [Q_WIDTH:0]   count_q, count_d;
    logic               full, empty, do_push, do_pop;

    assign full    = (count_q == (Q_WIDTH+1)'(Q_DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = en_i && push_i && !full;
    assign do_pop  = en_i && pop_i && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && do_push) mem_q[tail_q] <= data_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

    // Producers are expected to honour the stall; a push into a full queue is lost.
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(en_i && push_i && full));

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter sharing one registered CDB between the ALU
//   reservation station (RS) and the load/store buffer (LSB).
//   Sys_clk/Sys_rst/Sys_rdy   : clock, sync active-high reset, global enable
//   RSCDB_*                   : RS result input (tag, value, next pc)
//   LSBCDB_*                  : LSB result input (tag, load data)
//   CDBRS_stall/CDBLSB_stall  : producer back-pressure (one slot of margin)
//   CDB_*                     : registered broadcast; CDB_src 0=RS 1=LSB
//   RoBCDB_pre_judge          : 0 flushes all pending results
module cdb_arbiter #(
    parameter int ADDR_WIDTH = cdb_arbiter_pkg::ADDR_WIDTH,
    parameter int RoB_WIDTH  = cdb_arbiter_pkg::RoB_WIDTH,
    parameter int Q_WIDTH    = 2
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  RSCDB_en,
    input  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index,
    input  logic [31:0]           RSCDB_value,
    input  logic [ADDR_WIDTH-1:0] RSCDB_next_pc,
    input  logic                  LSBCDB_en,
    input  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index,
    input  logic [31:0]           LSBCDB_value,
    output logic                  CDBRS_stall,
    output logic                  CDBLSB_stall,
    output logic                  CDB_en,
    output logic [RoB_WIDTH-1:0]  CDB_RoB_index,
    output logic [31:0]           CDB_value,
    output logic [ADDR_WIDTH-1:0] CDB_next_pc,
    output logic                  CDB_src,
    input  logic                  RoBCDB_pre_judge
);

    import cdb_arbiter_pkg::*;

    localparam int Q_DEPTH = 1 << Q_WIDTH;
    localparam int DATA_W  = RoB_WIDTH + 32 + ADDR_WIDTH;

    logic [DATA_W-1:0] rs_head, lsb_head, sel_head;
    logic [Q_WIDTH:0]  rs_cnt, lsb_cnt;
    logic              flush, rs_ne, lsb_ne, grant_rs, grant_lsb;

    logic                  cdb_en_q, cdb_en_d;
    logic [RoB_WIDTH-1:0]  cdb_idx_q, cdb_idx_d;
    logic [31:0]           cdb_val_q, cdb_val_d;
    logic [ADDR_WIDTH-1:0] cdb_pc_q, cdb_pc_d;
    logic                  cdb_src_q, cdb_src_d;
    logic                  last_grant_q, last_grant_d;

    assign flush = !RoBCDB_pre_judge;

    // Entries are packed {tag, value, next_pc}; LSB stores a zero pc so the
    // broadcast needs no per-source muxing of that field.
    cdb_result_queue #(.Q_WIDTH(Q_WIDTH), .DATA_W(DATA_W)) u_rs_q (
        .clk_i   (Sys_clk),
        .rst_i   (Sys_rst),
        .en_i    (Sys_rdy),
        .flush_i (flush),
        .push_i  (RSCDB_en),
        .data_i  ({RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc}),
        .pop_i   (grant_rs),
        .head_o  (rs_head),
        .count_o (rs_cnt)
    );

    cdb_result_queue #(.Q_WIDTH(Q_WIDTH), .DATA_W(DATA_W)) u_lsb_q (
        .clk_i   (Sys_clk),
        .rst_i   (Sys_rst),
        .en_i    (Sys_rdy),
        .flush_i (flush),
        .push_i  (LSBCDB_en),
        .data_i  ({LSBCDB_RoB_index, LSBCDB_value, {ADDR_WIDTH{1'b0}}}),
        .pop_i   (grant_lsb),
        .head_o  (lsb_head),
        .count_o (lsb_cnt)
    );

    assign rs_ne  = (rs_cnt != '0);
    assign lsb_ne = (lsb_cnt != '0);

    // On a tie the source that did not win last time gets the bus.
    assign grant_rs  = rs_ne  && (!lsb_ne || last_grant_q == SRC_LSB);
    assign grant_lsb = lsb_ne && (!rs_ne  || last_grant_q == SRC_RS);
    assign sel_head  = grant_rs ? rs_head : lsb_head;

    always_comb begin
        cdb_en_d     = cdb_en_q;
        cdb_idx_d    = cdb_idx_q;
        cdb_val_d    = cdb_val_q;
        cdb_pc_d     = cdb_pc_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        if (flush) begin
            cdb_en_d  = 1'b0;
            cdb_idx_d = '0;
            cdb_val_d = '0;
            cdb_pc_d  = '0;
            cdb_src_d = SRC_RS;
        end else if (Sys_rdy) begin
            if (grant_rs || grant_lsb) begin
                cdb_en_d     = 1'b1;
                cdb_idx_d    = sel_head[DATA_W-1 -: RoB_WIDTH];
                cdb_val_d    = sel_head[ADDR_WIDTH +: 32];
                cdb_pc_d     = sel_head[ADDR_WIDTH-1:0];
                cdb_src_d    = grant_rs ? SRC_RS : SRC_LSB;
                last_grant_d = grant_rs ? SRC_RS : SRC_LSB;
            end else begin
                cdb_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            cdb_en_q     <= 1'b0;
            cdb_idx_q    <= '0;
            cdb_val_q    <= '0;
            cdb_pc_q     <= '0;
            cdb_src_q    <= SRC_RS;
            last_grant_q <= SRC_LSB;
        end else begin
            cdb_en_q     <= cdb_en_d;
            cdb_idx_q    <= cdb_idx_d;
            cdb_val_q    <= cdb_val_d;
            cdb_pc_q     <= cdb_pc_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Stall one entry early so a result already in flight still fits.
    assign CDBRS_stall  = (rs_cnt  >= (Q_WIDTH+1)'(Q_DEPTH-1));
    assign CDBLSB_stall = (lsb_cnt >= (Q_WIDTH+1)'(Q_DEPTH-1));

    assign CDB_en        = cdb_en_q;
    assign CDB_RoB_index = cdb_idx_q;
    assign CDB_value     = cdb_val_q;
    assign CDB_next_pc   = cdb_pc_q;
    assign CDB_src       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst = 1'b1;
    logic        Sys_rdy = 1'b0;
    logic        RSCDB_en = 1'b0;
    logic [7:0]  RSCDB_RoB_index = '0;
    logic [31:0] RSCDB_value = '0;
    logic [31:0] RSCDB_next_pc = '0;
    logic        LSBCDB_en = 1'b0;
    logic [7:0]  LSBCDB_RoB_index = '0;
    logic [31:0] LSBCDB_value = '0;
    logic        CDBRS_stall, CDBLSB_stall;
    logic        CDB_en;
    logic [7:0]  CDB_RoB_index;
    logic [31:0] CDB_value;
    logic [31:0] CDB_next_pc;
    logic        CDB_src;
    logic        RoBCDB_pre_judge = 1'b1;

    cdb_arbiter dut (
        .Sys_clk          (Sys_clk),
        .Sys_rst          (Sys_rst),
        .Sys_rdy          (Sys_rdy),
        .RSCDB_en         (RSCDB_en),
        .RSCDB_RoB_index  (RSCDB_RoB_index),
        .RSCDB_value      (RSCDB_value),
        .RSCDB_next_pc    (RSCDB_next_pc),
        .LSBCDB_en        (LSBCDB_en),
        .LSBCDB_RoB_index (LSBCDB_RoB_index),
        .LSBCDB_value     (LSBCDB_value),
        .CDBRS_stall      (CDBRS_stall),
        .CDBLSB_stall     (CDBLSB_stall),
        .CDB_en           (CDB_en),
        .CDB_RoB_index    (CDB_RoB_index),
        .CDB_value        (CDB_value),
        .CDB_next_pc      (CDB_next_pc),
        .CDB_src          (CDB_src),
        .RoBCDB_pre_judge (RoBCDB_pre_judge)
    );

    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] val;
        logic [31:0] pc;
    } exp_t;

    exp_t rs_exp[$];
    exp_t lsb_exp[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_live;

    // Scoreboard monitor: every fresh broadcast must match the oldest
    // outstanding result of the source it claims to come from.
    always @(posedge Sys_clk) begin
        mon_live = Sys_rdy && RoBCDB_pre_judge && !Sys_rst;
        #1;
        if (mon_live && CDB_en) begin
            n_cmp++;
            if (CDB_src == 1'b0 && rs_exp.size() == 0) begin
                n_err++;
                $display("FAIL sb_rs_extra: got idx=%0h, none expected", CDB_RoB_index);
            end else if (CDB_src == 1'b1 && lsb_exp.size() == 0) begin
                n_err++;
                $display("FAIL sb_lsb_extra: got idx=%0h, none expected", CDB_RoB_index);
            end else begin
                mon_e = (CDB_src == 1'b0) ? rs_exp.pop_front() : lsb_exp.pop_front();
                if ({CDB_RoB_index, CDB_value, CDB_next_pc} !== {mon_e.idx, mon_e.val, mon_e.pc}) begin
                    n_err++;
                    $display("FAIL sb_entry src=%0d: got %0h/%0h/%0h want %0h/%0h/%0h", CDB_src,
                             CDB_RoB_index, CDB_value, CDB_next_pc, mon_e.idx, mon_e.val, mon_e.pc);
                end
            end
        end
    end

    // Records accepted stimulus into the scoreboard, then advances one edge.
    task automatic tick();
        if (Sys_rdy && RoBCDB_pre_judge && !Sys_rst) begin
            if (RSCDB_en)  rs_exp.push_back('{RSCDB_RoB_index, RSCDB_value, RSCDB_next_pc});
            if (LSBCDB_en) lsb_exp.push_back('{LSBCDB_RoB_index, LSBCDB_value, 32'h0});
        end
        @(posedge Sys_clk);
        #2;
    endtask

    task automatic idle();
        RSCDB_en  = 1'b0;
        LSBCDB_en = 1'b0;
    endtask

    task automatic do_reset();
        Sys_rst = 1'b1;
        Sys_rdy = 1'b1;
        RoBCDB_pre_judge = 1'b1;
        tick();
        tick();
        Sys_rst = 1'b0;
        idle();
        rs_exp.delete();
        lsb_exp.delete();
    endtask

    task automatic test_reset();
        RSCDB_en = 1'b1; RSCDB_RoB_index = 8'h3c; RSCDB_value = 32'hdead; RSCDB_next_pc = 32'hbeef;
        LSBCDB_en = 1'b1; LSBCDB_RoB_index = 8'h3d; LSBCDB_value = 32'hcafe;
        Sys_rst = 1'b1; Sys_rdy = 1'b1;
        tick(); tick();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b want 0", CDB_en); end
        n_cmp++; if (CDB_RoB_index !== 8'h0) begin n_err++; $display("FAIL reset_idx: got %0h want 0", CDB_RoB_index); end
        n_cmp++; if (CDB_value !== 32'h0) begin n_err++; $display("FAIL reset_val: got %0h want 0", CDB_value); end
        n_cmp++; if (CDB_next_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", CDB_next_pc); end
        n_cmp++; if (CDB_src !== 1'b0) begin n_err++; $display("FAIL reset_src: got %0b want 0", CDB_src); end
        n_cmp++; if ({CDBRS_stall, CDBLSB_stall} !== 2'b00) begin n_err++; $display("FAIL reset_stall: got %b want 00", {CDBRS_stall, CDBLSB_stall}); end
        do_reset();
        tick();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL reset_empty_q: got en=%0b want 0", CDB_en); end
    endtask

    task automatic test_single();
        do_reset();
        RSCDB_en = 1'b1; RSCDB_RoB_index = 8'd5; RSCDB_value = 32'h11; RSCDB_next_pc = 32'h100;
        tick();
        idle();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got en=%0b want 0", CDB_en); end
        tick();
        n_cmp++;
        if ({CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src} !== {1'b1, 8'd5, 32'h11, 32'h100, 1'b0}) begin
            n_err++;
            $display("FAIL single_bcast: got en=%0b %0h/%0h/%0h src=%0b want 1 5/11/100 src=0",
                     CDB_en, CDB_RoB_index, CDB_value, CDB_next_pc, CDB_src);
        end
        tick();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL single_done: got en=%0b want 0", CDB_en); end
    endtask

    task automatic test_tie();
        do_reset();
        RSCDB_en = 1'b1;  RSCDB_RoB_index = 8'd1;  RSCDB_value = 32'haa; RSCDB_next_pc = 32'h200;
        LSBCDB_en = 1'b1; LSBCDB_RoB_index = 8'd2; LSBCDB_value = 32'hbb;
        tick();
        idle();
        tick();
        n_cmp++;
        if ({CDB_en, CDB_src, CDB_RoB_index} !== {1'b1, 1'b0, 8'd1}) begin
            n_err++; $display("FAIL tie_first: got en=%0b src=%0b idx=%0h want 1 0 1", CDB_en, CDB_src, CDB_RoB_index);
        end
        tick();
        n_cmp++;
        if ({CDB_en, CDB_src, CDB_RoB_index, CDB_next_pc} !== {1'b1, 1'b1, 8'd2, 32'h0}) begin
            n_err++; $display("FAIL tie_second: got en=%0b src=%0b idx=%0h pc=%0h want 1 1 2 0",
                              CDB_en, CDB_src, CDB_RoB_index, CDB_next_pc);
        end
        tick();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL tie_done: got en=%0b want 0", CDB_en); end
    endtask

    task automatic test_saturation();
        int   rk = 0, lk = 0;
        logic exp_src = 1'b0;
        bit   seen_rs_stall = 1'b0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            RSCDB_en = !CDBRS_stall;
            if (RSCDB_en) begin
                RSCDB_RoB_index = 8'h10 + 8'(rk); RSCDB_value = 32'h1000 + rk; RSCDB_next_pc = 32'h4000 + 4 * rk;
                rk++;
            end
            LSBCDB_en = !CDBLSB_stall;
            if (LSBCDB_en) begin
                LSBCDB_RoB_index = 8'h80 + 8'(lk); LSBCDB_value = 32'h2000 + lk;
                lk++;
            end
            tick();
            if (CDBRS_stall) seen_rs_stall = 1'b1;
            if (CDB_en) begin
                n_cmp++;
                if (CDB_src !== exp_src) begin
                    n_err++; $display("FAIL sat_alternate cycle %0d: got src=%0b want %0b", c, CDB_src, exp_src);
                end
                exp_src = ~exp_src;
            end
        end
        idle();
        for (int i = 0; i < 20 && (rs_exp.size() != 0 || lsb_exp.size() != 0); i++) tick();
        n_cmp++; if (!seen_rs_stall) begin n_err++; $display("FAIL sat_rs_stall: got never-high want high"); end
        n_cmp++;
        if (rs_exp.size() != 0 || lsb_exp.size() != 0) begin
            n_err++; $display("FAIL sat_drain: got %0d/%0d left want 0/0", rs_exp.size(), lsb_exp.size());
        end
    endtask

    task automatic test_wrap();
        int got = 0;
        do_reset();
        for (int c = 0; c < 30 && got < 10; c++) begin
            if (c < 10) begin
                RSCDB_en = 1'b1; RSCDB_RoB_index = 8'(c); RSCDB_value = 32'h500 + c; RSCDB_next_pc = 32'(4 * c);
            end else begin
                idle();
            end
            tick();
            if (CDB_en) begin
                n_cmp++;
                if (CDB_RoB_index !== 8'(got)) begin
                    n_err++; $display("FAIL wrap_order: got idx=%0h want %0h", CDB_RoB_index, got);
                end
                got++;
            end
        end
        idle();
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL wrap_count: got %0d want 10", got); end
        tick();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL wrap_done: got en=%0b want 0", CDB_en); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            RSCDB_en = !CDBRS_stall;
            RSCDB_RoB_index = 8'h20 + 8'(c); RSCDB_value = 32'h20 + c; RSCDB_next_pc = 32'h800 + c;
            LSBCDB_en = !CDBLSB_stall;
            LSBCDB_RoB_index = 8'h30 + 8'(c); LSBCDB_value = 32'h30 + c;
            tick();
        end
        idle();
        n_cmp++; if (CDBLSB_stall !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall: got %0b want 1", CDBLSB_stall); end
        RSCDB_en = 1'b1; RSCDB_RoB_index = 8'h77; RSCDB_value = 32'h77; RSCDB_next_pc = 32'h77;
        RoBCDB_pre_judge = 1'b0;
        tick();
        RoBCDB_pre_judge = 1'b1;
        idle();
        rs_exp.delete();
        lsb_exp.delete();
        n_cmp++;
        if ({CDB_en, CDB_RoB_index, CDB_value} !== {1'b0, 8'h0, 32'h0}) begin
            n_err++; $display("FAIL flush_cdb: got en=%0b idx=%0h val=%0h want 0 0 0", CDB_en, CDB_RoB_index, CDB_value);
        end
        n_cmp++;
        if ({CDBRS_stall, CDBLSB_stall} !== 2'b00) begin
            n_err++; $display("FAIL flush_stall: got %b want 00", {CDBRS_stall, CDBLSB_stall});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL flush_empty %0d: got en=%0b want 0", i, CDB_en); end
        end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        RSCDB_en = 1'b1;  RSCDB_RoB_index = 8'h40;  RSCDB_value = 32'h4000; RSCDB_next_pc = 32'h40;
        LSBCDB_en = 1'b1; LSBCDB_RoB_index = 8'h50; LSBCDB_value = 32'h5000;
        tick();
        RSCDB_RoB_index = 8'h41;  RSCDB_value = 32'h4001; RSCDB_next_pc = 32'h44;
        LSBCDB_RoB_index = 8'h51; LSBCDB_value = 32'h5001;
        tick();
        Sys_rdy = 1'b0;
        RSCDB_RoB_index = 8'h99; LSBCDB_RoB_index = 8'h98;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({CDB_en, CDB_src, CDB_RoB_index, CDB_value} !== {1'b1, 1'b0, 8'h40, 32'h4000}) begin
                n_err++; $display("FAIL rdy_hold %0d: got en=%0b src=%0b idx=%0h val=%0h want 1 0 40 4000",
                                  i, CDB_en, CDB_src, CDB_RoB_index, CDB_value);
            end
        end
        idle();
        Sys_rdy = 1'b1;
        tick();
        n_cmp++;
        if ({CDB_en, CDB_src, CDB_RoB_index} !== {1'b1, 1'b1, 8'h50}) begin
            n_err++; $display("FAIL rdy_resume1: got en=%0b src=%0b idx=%0h want 1 1 50", CDB_en, CDB_src, CDB_RoB_index);
        end
        tick();
        n_cmp++;
        if ({CDB_en, CDB_src, CDB_RoB_index} !== {1'b1, 1'b0, 8'h41}) begin
            n_err++; $display("FAIL rdy_resume2: got en=%0b src=%0b idx=%0h want 1 0 41", CDB_en, CDB_src, CDB_RoB_index);
        end
        tick();
        n_cmp++;
        if ({CDB_en, CDB_src, CDB_RoB_index} !== {1'b1, 1'b1, 8'h51}) begin
            n_err++; $display("FAIL rdy_resume3: got en=%0b src=%0b idx=%0h want 1 1 51", CDB_en, CDB_src, CDB_RoB_index);
        end
        tick();
        n_cmp++; if (CDB_en !== 1'b0) begin n_err++; $display("FAIL rdy_done: got en=%0b want 0", CDB_en); end
        n_cmp++;
        if (rs_exp.size() != 0 || lsb_exp.size() != 0) begin
            n_err++; $display("FAIL rdy_sb_left: got %0d/%0d want 0/0", rs_exp.size(), lsb_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_saturation();
        test_wrap();
        test_flush();
        test_rdy_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got no end by 200000 want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
